// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg: 640x480 timing constants, tile codes and colour palette      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vga_pkg;

   localparam logic [9:0] HACTIVE   = 10'd640;
   localparam logic [9:0] HFP       = 10'd16;
   localparam logic [9:0] HSYNC     = 10'd96;
   localparam logic [9:0] HFULLSCAN = 10'd800;

   localparam logic [9:0] VACTIVE   = 10'd480;
   localparam logic [9:0] VFP       = 10'd10;
   localparam logic [9:0] VSYNC     = 10'd2;
   localparam logic [9:0] VFULLSCAN = 10'd525;

   localparam logic [9:0] HSYNC_START = HACTIVE + HFP;
   localparam logic [9:0] HSYNC_END   = HSYNC_START + HSYNC - 10'd1;
   localparam logic [9:0] VSYNC_START = VACTIVE + VFP;
   localparam logic [9:0] VSYNC_END   = VSYNC_START + VSYNC - 10'd1;

   localparam logic [4:0] c_BLOCK_DURATION = 5'd19;

   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      BODY  = 3'd1,
      HEAD  = 3'd2,
      FOOD  = 3'd3,
      WALL  = 3'd4
   } tile_t;

   // {r[1:0], g[1:0], b[1:0]}
   localparam logic [5:0] c_PAL_EMPTY = 6'b000000;
   localparam logic [5:0] c_PAL_BODY  = 6'b001100;
   localparam logic [5:0] c_PAL_HEAD  = 6'b111100;
   localparam logic [5:0] c_PAL_FOOD  = 6'b110000;
   localparam logic [5:0] c_PAL_WALL  = 6'b111111;
   localparam logic [5:0] c_PAL_OTHER = 6'b010101;

   function automatic logic [5:0] palette(input logic [2:0] code, input logic blink);
      logic [5:0] v;
      v = c_PAL_OTHER;
      case (tile_t'(code))
         EMPTY:   v = c_PAL_EMPTY;
         BODY:    v = c_PAL_BODY;
         HEAD:    v = c_PAL_HEAD;
         FOOD:    v = blink ? c_PAL_EMPTY : c_PAL_FOOD;
         WALL:    v = c_PAL_WALL;
         default: v = c_PAL_OTHER;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_sync_gen: stage-3 hsync/vsync registers and blink frame counter   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int BLINK_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] i_row,
   input  logic [9:0] i_col,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_blink
);

   logic       r_hsync;
   logic       r_vsync;
   logic [4:0] r_frame_cnt;

   logic w_in_frame;
   logic w_hs_on;
   logic w_vs_on;
   logic w_frame_tick;

   // Counters outside the scan window never pulse sync, even on a matching row/col.
   assign w_in_frame   = (i_row < HFULLSCAN) && (i_col < VFULLSCAN);
   assign w_hs_on      = w_in_frame && (i_row >= HSYNC_START) && (i_row <= HSYNC_END);
   assign w_vs_on      = w_in_frame && (i_col >= VSYNC_START) && (i_col <= VSYNC_END);
   assign w_frame_tick = (i_row == 10'd0) && (i_col == VACTIVE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hsync     <= 1'b1;
         r_vsync     <= 1'b1;
         r_frame_cnt <= 5'd0;
      end else begin
         r_hsync <= ~w_hs_on;
         r_vsync <= ~w_vs_on;
         if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
         end
      end
   end

   assign o_hsync = r_hsync;
   assign o_vsync = r_vsync;
   assign o_blink = r_frame_cnt[BLINK_BIT];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pixel_out: 3-stage tile fetch / palette / sync output pipeline    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_pixel_out
   import vga_pkg::*;
#(
   parameter int PIPE_LAT  = 3,
   parameter int BLINK_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] row,
   input  logic [9:0] col,
   input  logic [9:0] raddr,
   input  logic       re,
   input  logic       updateoutput,
   input  logic [2:0] mem_rdata,
   output logic [9:0] mem_raddr,
   output logic       mem_re,
   output logic [4:0] next_duration,
   output logic       hsync,
   output logic       vsync,
   output logic [5:0] rgb
);

   if (PIPE_LAT != 3) begin : g_pipe_lat_check
      $error("vga_pixel_out: pipeline is fixed at 3 stages");
   end

   logic [9:0] r_row_d1;
   logic [9:0] r_col_d1;
   logic [9:0] r_raddr_d1;
   logic       r_re_d1;
   logic       r_upd_d1;

   logic [9:0] r_row_d2;
   logic [9:0] r_col_d2;
   logic       r_re_d2;
   logic       r_upd_d2;

   logic [2:0] r_tile_q;
   logic [5:0] r_rgb;

   logic [2:0] w_tile_nx;
   logic       w_active_d2;
   logic       w_blink;

   // Tile RAM answers one cycle after mem_re, so a same-cycle update must see it directly.
   assign w_tile_nx   = r_re_d2 ? mem_rdata : r_tile_q;
   assign w_active_d2 = (r_row_d2 < HACTIVE) && (r_col_d2 < VACTIVE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row_d1   <= '0;
         r_col_d1   <= '0;
         r_raddr_d1 <= '0;
         r_re_d1    <= 1'b0;
         r_upd_d1   <= 1'b0;
         r_row_d2   <= '0;
         r_col_d2   <= '0;
         r_re_d2    <= 1'b0;
         r_upd_d2   <= 1'b0;
         r_tile_q   <= EMPTY;
         r_rgb      <= c_PAL_EMPTY;
      end else begin
         r_row_d1   <= row;
         r_col_d1   <= col;
         r_raddr_d1 <= raddr;
         r_re_d1    <= re;
         r_upd_d1   <= updateoutput;
         r_row_d2   <= r_row_d1;
         r_col_d2   <= r_col_d1;
         r_re_d2    <= r_re_d1;
         r_upd_d2   <= r_upd_d1;
         r_tile_q   <= w_tile_nx;
         if (!w_active_d2) begin
            r_rgb <= c_PAL_EMPTY;
         end else if (r_upd_d2) begin
            r_rgb <= palette(w_tile_nx, w_blink);
         end
      end
   end

   vga_sync_gen #(
      .BLINK_BIT (BLINK_BIT)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_row   (r_row_d2),
      .i_col   (r_col_d2),
      .o_hsync (hsync),
      .o_vsync (vsync),
      .o_blink (w_blink)
   );

   assign mem_raddr     = r_raddr_d1;
   assign mem_re        = r_re_d1;
   assign next_duration = c_BLOCK_DURATION;
   assign rgb           = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_pixel_out: directed vector table plus multi-cycle sequences    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_vga_pixel_out;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] row;
   logic [9:0] col;
   logic [9:0] raddr;
   logic       re;
   logic       updateoutput;
   logic [2:0] mem_rdata;
   logic [9:0] mem_raddr;
   logic       mem_re;
   logic [4:0] next_duration;
   logic       hsync;
   logic       vsync;
   logic [5:0] rgb;

   logic [2:0] ram [0:1023];
   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [9:0] row;
      logic [9:0] col;
      logic       re;
      logic [9:0] raddr;
      logic       upd;
      logic       hs;
      logic       vs;
      logic [5:0] rgb;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   vga_pixel_out #(
      .PIPE_LAT  (3),
      .BLINK_BIT (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .row           (row),
      .col           (col),
      .raddr         (raddr),
      .re            (re),
      .updateoutput  (updateoutput),
      .mem_rdata     (mem_rdata),
      .mem_raddr     (mem_raddr),
      .mem_re        (mem_re),
      .next_duration (next_duration),
      .hsync         (hsync),
      .vsync         (vsync),
      .rgb           (rgb)
   );

   // Synchronous tile RAM: data valid one cycle after mem_re.
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= ram[mem_raddr];
   end

   function automatic vec_t mk(int r, int c, bit e, int a, bit u, bit hs, bit vs, int px);
      vec_t v;
      v.row = 10'(r); v.col = 10'(c); v.re = e; v.raddr = 10'(a); v.upd = u;
      v.hs = hs; v.vs = vs; v.rgb = 6'(px);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input int r, input int c, input bit e, input int a, input bit u);
      row = 10'(r); col = 10'(c); re = e; raddr = 10'(a); updateoutput = u;
      tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   initial begin
      typedef struct { logic hs; logic vs; } sexp_t;
      sexp_t q[$];
      sexp_t s;

      reset = 1'b1; row = '0; col = '0; raddr = '0; re = 1'b0; updateoutput = 1'b0;
      for (int i = 0; i < 1024; i++) ram[i] = 3'd0;
      ram[5] = 3'd1; ram[6] = 3'd2; ram[7] = 3'd4; ram[8] = 3'd3; ram[9] = 3'd7;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_rgb", rgb, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_raddr", mem_raddr, 0);
      check("rst_next_duration", next_duration, 19);
      check("rst_frame_cnt", dut.u_sync.r_frame_cnt, 0);
      check("rst_tile_q", dut.r_tile_q, 0);
      reset = 1'b0;

      // ---------------- vector table: {row,col,re,raddr,upd} -> {hs,vs,rgb} ----------------
      vecs.push_back(mk(  18,   0, 0, 0, 0, 1, 1, 'h00));
      vecs.push_back(mk(  19,   0, 1, 5, 0, 1, 1, 'h00));
      vecs.push_back(mk(  20,   0, 0, 0, 1, 1, 1, 'h0C));
      vecs.push_back(mk(  21,   0, 0, 0, 0, 1, 1, 'h0C));
      vecs.push_back(mk(  22,   0, 0, 0, 0, 1, 1, 'h0C));
      vecs.push_back(mk(  50,   0, 1, 7, 1, 1, 1, 'h3F));
      vecs.push_back(mk(  51,   0, 0, 0, 0, 1, 1, 'h3F));
      vecs.push_back(mk(  52,   0, 1, 6, 0, 1, 1, 'h3F));
      vecs.push_back(mk(  53,   0, 0, 0, 1, 1, 1, 'h3C));
      vecs.push_back(mk( 655,   0, 0, 0, 1, 1, 1, 'h00));
      vecs.push_back(mk( 656,   0, 0, 0, 0, 0, 1, 'h00));
      vecs.push_back(mk( 751,   0, 0, 0, 0, 0, 1, 'h00));
      vecs.push_back(mk( 752,   0, 0, 0, 0, 1, 1, 'h00));
      vecs.push_back(mk( 639, 479, 1, 8, 1, 1, 1, 'h30));
      vecs.push_back(mk( 640, 479, 0, 0, 1, 1, 1, 'h00));
      vecs.push_back(mk( 100, 480, 0, 0, 1, 1, 1, 'h00));
      vecs.push_back(mk( 100, 490, 0, 0, 0, 1, 0, 'h00));
      vecs.push_back(mk( 700, 491, 0, 0, 0, 0, 0, 'h00));
      vecs.push_back(mk( 100, 492, 0, 0, 0, 1, 1, 'h00));
      vecs.push_back(mk( 100, 489, 0, 0, 0, 1, 1, 'h00));
      vecs.push_back(mk( 900, 100, 0, 0, 1, 1, 1, 'h00));
      vecs.push_back(mk( 700, 600, 0, 0, 1, 1, 1, 'h00));
      vecs.push_back(mk( 900, 490, 0, 0, 0, 1, 1, 'h00));
      vecs.push_back(mk(1023,1023, 0, 0, 1, 1, 1, 'h00));
      vecs.push_back(mk(  10,  10, 1, 9, 1, 1, 1, 'h15));
      vecs.push_back(mk(  11,  10, 0, 0, 0, 1, 1, 'h15));
      vecs.push_back(mk(  12,  10, 0, 0, 0, 1, 1, 'h15));
      vecs.push_back(mk(  13,  10, 0, 0, 0, 1, 1, 'h15));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].row, vecs[i].col, vecs[i].re, vecs[i].raddr, vecs[i].upd);
         if (i >= 2) begin
            check($sformatf("vec%0d_{hs,vs,rgb}", i - 2), {hsync, vsync, rgb},
                  {vecs[i-2].hs, vecs[i-2].vs, vecs[i-2].rgb});
         end
      end
      check("next_duration_run", next_duration, 19);

      // ---------------- sync sweep around key lines, empty tiles ----------------
      reset = 1'b1; tick(); reset = 1'b0;
      foreach (vecs[k]) begin end
      for (int li = 0; li < 6; li++) begin
         int c;
         case (li)
            0: c = 0;   1: c = 489; 2: c = 490;
            3: c = 491; 4: c = 492; default: c = 524;
         endcase
         for (int r = 0; r < 800; r++) begin
            apply(r, c, 1, 0, 1);
            s.hs = !(r >= 656 && r <= 751);
            s.vs = !(c == 490 || c == 491);
            q.push_back(s);
            if (q.size() == 3) begin
               s = q.pop_front();
               check($sformatf("sweep_r%0d_c%0d", (r + 798) % 800, c), {hsync, vsync, rgb},
                     {s.hs, s.vs, 6'h00});
            end
         end
      end
      q.delete();

      // ---------------- food blink over 33 frames ----------------
      reset = 1'b1; tick(); reset = 1'b0;
      for (int f = 0; f <= 32; f++) begin
         if (f > 0) apply(0, 480, 1, 8, 1);
         apply(5, 5, 1, 8, 1);
         apply(5, 5, 1, 8, 1);
         apply(5, 5, 1, 8, 1);
         check($sformatf("blink_rgb_f%0d", f), rgb, ((f % 32) < 16) ? 'h30 : 'h00);
         check($sformatf("blink_cnt_f%0d", f), dut.u_sync.r_frame_cnt, f % 32);
      end

      // ---------------- reset mid-frame ----------------
      apply(0, 480, 0, 0, 0);
      apply(297, 200, 1, 5, 1);
      apply(298, 200, 1, 5, 1);
      apply(299, 200, 1, 5, 1);
      check("pre_rst_rgb", rgb, 'h0C);
      check("pre_rst_frame_cnt", dut.u_sync.r_frame_cnt, 1);
      check("pre_rst_mem_re", mem_re, 1);
      reset = 1'b1;
      apply(300, 200, 1, 5, 1);
      check("mid_rst_hsync", hsync, 1);
      check("mid_rst_vsync", vsync, 1);
      check("mid_rst_rgb", rgb, 0);
      check("mid_rst_mem_re", mem_re, 0);
      check("mid_rst_mem_raddr", mem_raddr, 0);
      check("mid_rst_frame_cnt", dut.u_sync.r_frame_cnt, 0);
      reset = 1'b0;
      apply(301, 200, 1, 9, 1);
      check("post_rst1_out", {hsync, vsync, rgb}, {1'b1, 1'b1, 6'h00});
      check("post_rst1_mem_re", mem_re, 1);
      check("post_rst1_mem_raddr", mem_raddr, 9);
      apply(302, 200, 1, 9, 1);
      check("post_rst2_out", {hsync, vsync, rgb}, {1'b1, 1'b1, 6'h00});
      apply(303, 200, 1, 9, 1);
      check("post_rst3_out", {hsync, vsync, rgb}, {1'b1, 1'b1, 6'h15});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
